// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation controller and the multiplier wrapper.
package rsa_pkg;

  localparam logic [1:0] OP_TO_MONT   = 2'd0;
  localparam logic [1:0] OP_SQUARE    = 2'd1;
  localparam logic [1:0] OP_MULT      = 2'd2;
  localparam logic [1:0] OP_FROM_MONT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rsa_cmd_arbiter.sv
// Merges GPIO/SPI start/stop pulses, gives stop priority and keeps busy/aborted/start_src.
module rsa_cmd_arbiter (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic gpio_start_cmd,
  input  logic gpio_stop_cmd,
  input  logic spi_start_cmd,
  input  logic spi_stop_cmd,
  input  logic active_i,
  input  logic finish_i,
  output logic start_acc_o,
  output logic stop_acc_o,
  output logic busy_o,
  output logic aborted_o,
  output logic start_src_o
);

  logic busy_q, busy_d;
  logic aborted_q, aborted_d;
  logic src_q, src_d;
  logic start_any, stop_any;

  // The accept strobes feed the sequencer's next-state logic directly; status is registered.
  always_comb begin
    start_any   = gpio_start_cmd | spi_start_cmd;
    stop_any    = gpio_stop_cmd | spi_stop_cmd;
    stop_acc_o  = ena & stop_any & active_i;
    start_acc_o = ena & start_any & ~stop_any & ~active_i;
  end

  always_comb begin
    busy_d    = busy_q;
    aborted_d = aborted_q;
    src_d     = src_q;
    if (start_acc_o) begin
      busy_d    = 1'b1;
      aborted_d = 1'b0;
      src_d     = ~gpio_start_cmd;
    end else if (stop_acc_o) begin
      busy_d    = 1'b0;
      aborted_d = 1'b1;
    end else if (finish_i) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      busy_q    <= 1'b0;
      aborted_q <= 1'b0;
      src_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      aborted_q <= aborted_d;
      src_q     <= src_d;
    end
  end

  assign busy_o      = busy_q;
  assign aborted_o   = aborted_q;
  assign start_src_o = src_q;

endmodule

// File: rtl/rsa_exp_sequencer.sv
// Left-to-right square-and-multiply controller driving the Montgomery multiplier handshake.
module rsa_exp_sequencer
  import rsa_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int IDX_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 ena,
  input  logic                 gpio_start_cmd,
  input  logic                 gpio_stop_cmd,
  input  logic                 spi_start_cmd,
  input  logic                 spi_stop_cmd,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic                 mmm_done,
  output logic                 mmm_start,
  output logic [1:0]           mmm_op,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 start_src,
  output logic [IDX_WIDTH-1:0] bit_idx,
  output state_t               dbg_state
);

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic                 start_acc, stop_acc, active, finish;

  assign active = (state_q != ST_IDLE);
  assign finish = ena & ~stop_acc & (state_q == ST_WAIT) & mmm_done & (op_q == OP_FROM_MONT);

  rsa_cmd_arbiter u_arb (
    .clk            (clk),
    .rstb           (rstb),
    .ena            (ena),
    .gpio_start_cmd (gpio_start_cmd),
    .gpio_stop_cmd  (gpio_stop_cmd),
    .spi_start_cmd  (spi_start_cmd),
    .spi_stop_cmd   (spi_stop_cmd),
    .active_i       (active),
    .finish_i       (finish),
    .start_acc_o    (start_acc),
    .stop_acc_o     (stop_acc),
    .busy_o         (busy),
    .aborted_o      (aborted),
    .start_src_o    (start_src)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      op_q    <= OP_TO_MONT;
      idx_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    if (stop_acc) begin
      state_d = ST_IDLE;
    end else if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            exp_d   = exponent;
            idx_d   = IDX_WIDTH'(EXP_WIDTH - 1);
            op_d    = OP_TO_MONT;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT: begin
          if (mmm_done) begin
            state_d = ST_ISSUE;
            if (op_q == OP_TO_MONT) begin
              op_d = OP_SQUARE;
            end else if (op_q == OP_FROM_MONT) begin
              state_d = ST_DONE;
            end else if (op_q == OP_SQUARE && exp_q[idx_q]) begin
              op_d = OP_MULT;
            end else if (idx_q == '0) begin
              op_d = OP_FROM_MONT;
            end else begin
              // Bit finished (square with a clear bit, or its multiply): move to the next lower bit.
              idx_d = idx_q - IDX_WIDTH'(1);
              op_d  = OP_SQUARE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mmm_start = ena & ~stop_acc & (state_q == ST_ISSUE);
    done      = ena & ~stop_acc & (state_q == ST_DONE);
    mmm_op    = op_q;
    bit_idx   = idx_q;
    dbg_state = state_q;
  end

endmodule
